// File: rtl/axi4l_mem_bridge_pkg.sv
// axi4l_mem_bridge_pkg: shared FSM/grant types, response codes, and the AXI4L_T struct macro
`ifndef AXI4L_T
`define AXI4L_T(AW, DW) \
  typedef struct packed { logic [(AW)-1:0] addr; logic [2:0] prot; } axi_ax_t; \
  typedef struct packed { logic [(DW)-1:0] data; logic [(DW)/8-1:0] strb; } axi_w_t; \
  typedef struct packed { logic [1:0] resp; } axi_b_t; \
  typedef struct packed { logic [(DW)-1:0] data; logic [1:0] resp; } axi_r_t; \
  typedef struct packed { axi_ax_t aw; logic aw_valid; axi_w_t w; logic w_valid; logic b_ready; \
                          axi_ax_t ar; logic ar_valid; logic r_ready; } axi_req_t; \
  typedef struct packed { logic aw_ready; logic w_ready; axi_b_t b; logic b_valid; \
                          logic ar_ready; axi_r_t r; logic r_valid; } axi_resp_t;
`endif

package axi4l_mem_bridge_pkg;
  typedef enum logic [2:0] {IDLE, WR_ACC, WR_RSP, RD_ACC, RD_WAIT, RD_RSP} bridge_state_e;
  typedef enum logic {WRITE, READ} grant_e;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi4l_mem_bridge_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; bit 0 = write, bit 1 = read, ties go opposite of last grant
module rr_arb2
  import axi4l_mem_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  grant_e     upd_grant,
  output logic [1:0] gnt
);
  grant_e last;
  always_ff @(posedge clk) begin
    if (rst) last <= WRITE;
    else if (upd) last <= upd_grant;
  end
  always_comb gnt = &req ? (last == WRITE ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/axi4l_mem_bridge.sv
// axi4l_mem_bridge: AXI4-Lite subordinate serialising reads/writes onto a 1-cycle-latency SRAM port.
// Define AXI4L_MEM_BRIDGE_PROT_CHECK_EN to block unprivileged accesses to the upper half of the window.
module axi4l_mem_bridge
  import axi4l_mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter longint unsigned MEM_BASE = 0,
  parameter longint unsigned MEM_SIZE = 4096,
  localparam int MEM_AW = $clog2(MEM_SIZE / (DATA_WIDTH / 8)),
  localparam int REQ_W = 2 * ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH / 8 + 11,
  localparam int RESP_W = DATA_WIDTH + 9
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic [REQ_W-1:0]        req_i,
  output logic [RESP_W-1:0]       resp_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [MEM_AW-1:0]       mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_strb_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
  `AXI4L_T(ADDR_WIDTH, DATA_WIDTH)
  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH:0] LO = (ADDR_WIDTH + 1)'(MEM_BASE);
  localparam logic [ADDR_WIDTH:0] HI = LO + (ADDR_WIDTH + 1)'(MEM_SIZE);
  axi_req_t req;
  axi_resp_t resp;
  bridge_state_e state;
  logic rng, wr_ok, rd_ok, upd, b_valid, r_valid;
  logic [1:0] gnt, b_resp, r_resp;
  logic [DATA_WIDTH-1:0] r_data;
  assign req = req_i;
  assign resp_o = resp;
  // extra top bit keeps MEM_BASE+MEM_SIZE = 2^ADDR_WIDTH from wrapping
  function automatic logic in_win(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} >= LO && {1'b0, a} < HI;
  endfunction
`ifdef AXI4L_MEM_BRIDGE_PROT_CHECK_EN
  localparam logic [ADDR_WIDTH:0] HALF = (ADDR_WIDTH + 1)'(MEM_SIZE / 2);
  function automatic logic upper(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} - LO) >= HALF;
  endfunction
  logic unused_prot;
  assign unused_prot = ^{req.aw.prot[2:1], req.ar.prot[2:1]};
  assign wr_ok = in_win(req.aw.addr) && (req.aw.prot[0] || !upper(req.aw.addr));
  assign rd_ok = in_win(req.ar.addr) && (req.ar.prot[0] || !upper(req.ar.addr));
`else
  logic unused_prot;
  assign unused_prot = ^{req.aw.prot, req.ar.prot};
  assign wr_ok = in_win(req.aw.addr);
  assign rd_ok = in_win(req.ar.addr);
`endif
  assign upd = (state == WR_RSP && req.b_ready) || (state == RD_RSP && req.r_ready);
  rr_arb2 u_arb (
    .clk      (clk_i),
    .rst      (srst_i),
    .req      ((state == IDLE && !srst_i) ? {req.ar_valid, req.aw_valid && req.w_valid} : 2'b00),
    .upd      (upd),
    .upd_grant(state == RD_RSP ? READ : WRITE),
    .gnt      (gnt)
  );
  assign resp = '{aw_ready: gnt[0], w_ready: gnt[0], b: '{resp: b_resp}, b_valid: b_valid,
                  ar_ready: gnt[1], r: '{data: r_data, resp: r_resp}, r_valid: r_valid};
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state <= IDLE;
      rng <= 1'b0;
      mem_req_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
      mem_strb_o <= '0;
      b_valid <= 1'b0;
      b_resp <= RESP_OKAY;
      r_valid <= 1'b0;
      r_data <= '0;
      r_resp <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (gnt[0]) begin
            state <= WR_ACC;
            rng <= wr_ok;
            mem_req_o <= wr_ok;
            mem_we_o <= 1'b1;
            mem_addr_o <= req.aw.addr[OFF +: MEM_AW];
            mem_wdata_o <= req.w.data;
            mem_strb_o <= req.w.strb;
          end else if (gnt[1]) begin
            state <= RD_ACC;
            rng <= rd_ok;
            mem_req_o <= rd_ok;
            mem_we_o <= 1'b0;
            mem_addr_o <= req.ar.addr[OFF +: MEM_AW];
          end
        end
        WR_ACC: begin
          state <= WR_RSP;
          mem_req_o <= 1'b0;
          mem_we_o <= 1'b0;
          b_valid <= 1'b1;
          b_resp <= rng ? RESP_OKAY : RESP_SLVERR;
        end
        WR_RSP: begin
          if (req.b_ready) begin
            state <= IDLE;
            b_valid <= 1'b0;
          end
        end
        RD_ACC: begin
          state <= RD_WAIT;
          mem_req_o <= 1'b0;
        end
        RD_WAIT: begin
          state <= RD_RSP;
          r_valid <= 1'b1;
          r_data <= rng ? mem_rdata_i : '0;
          r_resp <= rng ? RESP_OKAY : RESP_SLVERR;
        end
        RD_RSP: begin
          if (req.r_ready) begin
            state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4l_mem_bridge.sv
// tb_axi4l_mem_bridge: directed + randomized checks of the bridge against a word-array reference model
module tb_axi4l_mem_bridge;
  localparam int AW = 32, DW = 32, MAW = 10;
  localparam longint BASE = 0, SIZE = 4096;
`ifdef AXI4L_MEM_BRIDGE_PROT_CHECK_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  `AXI4L_T(AW, DW)
  logic clk = 1'b0, srst = 1'b1;
  axi_req_t req;
  axi_resp_t resp;
  logic mem_req, mem_we;
  logic [MAW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0] mem_strb;
  logic [31:0] sram [1024];
  logic [31:0] ref_mem [1024];
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  axi4l_mem_bridge dut (
    .clk_i(clk), .srst_i(srst), .req_i(req), .resp_o(resp),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb), .mem_rdata_i(mem_rdata)
  );
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) if (mem_strb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else mem_rdata <= sram[mem_addr];
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  function automatic bit allowed(input logic [31:0] a, input logic [2:0] p);
    longint off = longint'(a) - BASE;
    return off >= 0 && off < SIZE && !(PROT && !p[0] && off >= SIZE / 2);
  endfunction
  function automatic int word_of(input logic [31:0] a);
    return int'(((longint'(a) - BASE) / (DW / 8)) % (SIZE / (DW / 8)));
  endfunction
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [2:0] p, input int hold, output int waited);
    bit ok = allowed(a, p);
    int w = word_of(a);
    int n = 0;
    req.aw.addr = a; req.aw.prot = p; req.aw_valid = 1'b1;
    req.w.data = d; req.w.strb = s; req.w_valid = 1'b1;
    req.b_ready = (hold == 0);
    #1;
    while (!resp.aw_ready && n < 20) begin @(posedge clk); #2; n++; end
    waited = n;
    chk("wr_ready", {resp.aw_ready, resp.w_ready, resp.ar_ready}, 3'b110);
    @(posedge clk); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    chk("wr_mem_req", mem_req, ok);
    chk("wr_mem_we", mem_we, 1);
    if (ok) begin
      chk("wr_mem_addr", mem_addr, w);
      chk("wr_mem_wdata", mem_wdata, d);
      chk("wr_mem_strb", mem_strb, s);
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    end
    chk("wr_b_early", resp.b_valid, 0);
    @(posedge clk); #1;
    chk("wr_b_valid", resp.b_valid, 1);
    chk("wr_b_resp", resp.b.resp, ok ? 2'b00 : 2'b10);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("wr_b_hold", {resp.b_valid, resp.b.resp}, {1'b1, ok ? 2'b00 : 2'b10});
    end
    req.b_ready = 1'b1;
    @(posedge clk); #1;
    chk("wr_b_done", resp.b_valid, 0);
  endtask
  task automatic do_read(input logic [31:0] a, input logic [2:0] p, input int hold);
    bit ok = allowed(a, p);
    int w = word_of(a);
    logic [31:0] exp = ok ? ref_mem[w] : 32'h0;
    int n = 0;
    req.ar.addr = a; req.ar.prot = p; req.ar_valid = 1'b1;
    req.r_ready = (hold == 0);
    #1;
    while (!resp.ar_ready && n < 20) begin @(posedge clk); #2; n++; end
    chk("rd_ready", {resp.aw_ready, resp.w_ready, resp.ar_ready}, 3'b001);
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    chk("rd_mem_req", mem_req, ok);
    chk("rd_mem_we", mem_we, 0);
    if (ok) chk("rd_mem_addr", mem_addr, w);
    chk("rd_r_early1", resp.r_valid, 0);
    @(posedge clk); #1;
    chk("rd_r_early2", {resp.r_valid, mem_req}, 2'b00);
    @(posedge clk); #1;
    chk("rd_r_valid", resp.r_valid, 1);
    chk("rd_r_data", resp.r.data, exp);
    chk("rd_r_resp", resp.r.resp, ok ? 2'b00 : 2'b10);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("rd_r_hold", {resp.r_valid, resp.r.data, resp.r.resp}, {1'b1, exp, ok ? 2'b00 : 2'b10});
    end
    req.r_ready = 1'b1;
    @(posedge clk); #1;
    chk("rd_r_done", resp.r_valid, 0);
  endtask
  initial begin
    int n;
    bit g [$];
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) begin sram[i] = '0; ref_mem[i] = '0; end
    mem_rdata = '0;
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp", resp, '0);
    chk("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata, mem_strb}, '0);
    srst = 1'b0;
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 0, n);
    do_read(32'h10, 3'b000, 0);
    do_read(32'h1000, 3'b000, 0);
    do_write(32'h2000, 32'h55AA55AA, 4'hF, 3'b000, 0, n);
    do_write(32'h13, 32'h00C0FFEE, 4'b0011, 3'b001, 1, n);
    do_read(32'h12, 3'b001, 2);
    do_write(32'h14, 32'h12345678, 4'h0, 3'b001, 0, n);
    do_read(32'h14, 3'b001, 0);
    // lone AW must not be accepted until W joins it
    req.aw.addr = 32'h30; req.aw.prot = 3'b001; req.aw_valid = 1'b1; req.w_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("lone_aw_wait", {resp.aw_ready, resp.w_ready}, 2'b00);
    end
    do_write(32'h30, 32'hA5A5A5A5, 4'hF, 3'b001, 0, n);
    chk("lone_aw_release", n, 0);
    // contended from reset: expect read, write, read
    srst = 1'b1;
    req.aw.addr = 32'h20; req.aw.prot = 3'b001; req.aw_valid = 1'b1;
    req.w.data = 32'h0BADF00D; req.w.strb = 4'hF; req.w_valid = 1'b1;
    req.ar.addr = 32'h10; req.ar.prot = 3'b001; req.ar_valid = 1'b1;
    req.b_ready = 1'b1; req.r_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_gated_ready", resp, '0);
    srst = 1'b0;
    #1;
    for (int i = 0; i < 40 && g.size() < 3; i++) begin
      if (resp.ar_ready) g.push_back(1'b1);
      if (resp.aw_ready) begin
        g.push_back(1'b0);
        chk("cont_w_ready", {resp.w_ready, resp.ar_ready}, 2'b10);
        ref_mem[8] = 32'h0BADF00D;
      end
      @(posedge clk); #2;
    end
    req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
    chk("cont_count", g.size(), 3);
    if (g.size() == 3) chk("cont_order", {g[0], g[1], g[2]}, 3'b101);
    repeat (6) @(posedge clk);
    #1;
    do_read(32'h20, 3'b001, 0);
    // reset while holding a read response
    req.ar.addr = 32'h10; req.ar.prot = 3'b001; req.ar_valid = 1'b1; req.r_ready = 1'b0;
    n = 0;
    #1;
    while (!resp.ar_ready && n < 20) begin @(posedge clk); #2; n++; end
    chk("srst_rd_ready", resp.ar_ready, 1);
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("srst_pre_rvalid", resp.r_valid, 1);
    srst = 1'b1;
    @(posedge clk); #1;
    chk("srst_resp", resp, '0);
    chk("srst_mem_req", mem_req, 0);
    srst = 1'b0;
    @(posedge clk); #1;
    chk("srst_idle", {resp.r_valid, resp.b_valid}, 2'b00);
    do_read(32'h10, 3'b001, 0);
`ifdef AXI4L_MEM_BRIDGE_PROT_CHECK_EN
    do_write(32'h900, 32'hFEEDFACE, 4'hF, 3'b001, 0, n);
    do_read(32'h900, 3'b000, 0);
    do_read(32'h900, 3'b001, 0);
`endif
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: a = $urandom_range(32'h1000, 32'h1FFF);
        1: a = 32'hFFFF_F000 + $urandom_range(0, 255);
        default: a = ($urandom_range(0, 1) ? 32'h800 : 32'h0) + $urandom_range(0, 63);
      endcase
      if ($urandom_range(0, 1))
        do_write(a, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), $urandom_range(0, 2), n);
      else
        do_read(a, 3'($urandom_range(0, 7)), $urandom_range(0, 2));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
